// File: rtl/vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// vga_plot_arbiter
//
// Shares the single VGA adapter plot port between up to four drawing engines.
// An engine wins the grant by round-robin and keeps it for a whole burst,
// which ends on a beat carrying req_last. Pixels are accepted over a
// valid/ready handshake. Off-screen pixels are consumed but not plotted.
// A watchdog revokes the grant from an engine that stalls too long.
//
// Parameters:
//   N_REQ    number of requesters (1..4)
//   X_MAX    visible width, valid x is 0..X_MAX-1
//   Y_MAX    visible height, valid y is 0..Y_MAX-1
//   TIMEOUT  idle burst cycles before the grant is revoked (>= 2)
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   req_valid/last     per-requester pixel valid / final pixel of burst
//   req_x/y/colour     packed per-requester pixel fields (8/7/3 bits each)
//   req_ready          per-requester accept, equal to the registered grant
//   grant              one-hot owner, zero when idle
//   vga_x/y/colour     registered pixel to the adapter
//   vga_plot           registered plot strobe
//   clip_count         saturating count of dropped off-screen pixels
//   timeout_err        one-cycle pulse when a grant is revoked
// -----------------------------------------------------------------------------
module vga_plot_arbiter #(
    parameter int N_REQ   = 2,
    parameter int X_MAX   = 160,
    parameter int Y_MAX   = 120,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ-1:0]   req_last,
    input  logic [8*N_REQ-1:0] req_x,
    input  logic [7*N_REQ-1:0] req_y,
    input  logic [3*N_REQ-1:0] req_colour,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   grant,
    output logic [7:0]         vga_x,
    output logic [6:0]         vga_y,
    output logic [2:0]         vga_colour,
    output logic               vga_plot,
    output logic [15:0]        clip_count,
    output logic               timeout_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] OWNER_INIT = IDX_W'(N_REQ - 1);
    // One bit wider than the coordinate so limits up to 256/128 still fit.
    localparam logic [8:0] X_LIM = 9'(X_MAX);
    localparam logic [7:0] Y_LIM = 8'(Y_MAX);

    typedef enum logic {
        S_IDLE,
        S_BURST
    } state_t;

    state_t             r_state, w_state_next;
    logic [N_REQ-1:0]   r_grant, w_grant_next;
    logic [IDX_W-1:0]   r_last_owner, w_last_owner_next;
    logic [WD_W-1:0]    r_wd, w_wd_next;
    logic               r_timeout_err, w_timeout_next;

    logic [7:0]         r_vga_x;
    logic [6:0]         r_vga_y;
    logic [2:0]         r_vga_colour;
    logic               r_vga_plot;
    logic [15:0]        r_clip_count;

    // Unpacked per-requester views of the packed buses.
    logic [7:0]         w_x      [N_REQ];
    logic [6:0]         w_y      [N_REQ];
    logic [2:0]         w_colour [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign w_x[gi]      = req_x[8*gi +: 8];
            assign w_y[gi]      = req_y[7*gi +: 7];
            assign w_colour[gi] = req_colour[3*gi +: 3];
        end
    endgenerate

    // Owner's beat, selected by the one-hot grant (zero when idle).
    logic [7:0]         w_sel_x;
    logic [6:0]         w_sel_y;
    logic [2:0]         w_sel_colour;
    logic [IDX_W-1:0]   w_owner_idx;
    logic               w_accept;
    logic               w_sel_last;
    logic               w_on_screen;

    always_comb begin
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_colour = '0;
        w_owner_idx  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_sel_x      = w_x[i];
                w_sel_y      = w_y[i];
                w_sel_colour = w_colour[i];
                w_owner_idx  = IDX_W'(i);
            end
        end
    end

    // req_ready mirrors the grant, so acceptance is simply valid & grant.
    assign w_accept    = (r_state == S_BURST) && |(req_valid & r_grant);
    assign w_sel_last  = |(req_last & r_grant);
    assign w_on_screen = ({1'b0, w_sel_x} < X_LIM) && ({1'b0, w_sel_y} < Y_LIM);

    // Round-robin: each valid candidate gets its distance from last_owner+1;
    // the nearest one wins. Distances are kept non-negative before the modulo.
    logic [N_REQ-1:0]   w_rr_onehot;
    int                 w_rr_dist;
    int                 w_rr_best;

    always_comb begin
        w_rr_onehot = '0;
        w_rr_dist   = 0;
        w_rr_best   = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            w_rr_dist = (i + 2 * N_REQ - int'(r_last_owner) - 1) % N_REQ;
            if (req_valid[i] && (w_rr_dist < w_rr_best)) begin
                w_rr_best      = w_rr_dist;
                w_rr_onehot    = '0;
                w_rr_onehot[i] = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_owner_next = r_last_owner;
        w_wd_next         = r_wd;
        w_timeout_next    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_wd_next = '0;
                if (|req_valid) begin
                    w_grant_next = w_rr_onehot;
                    w_state_next = S_BURST;
                end
            end
            S_BURST: begin
                if (w_accept) begin
                    w_wd_next = '0;
                    if (w_sel_last) begin
                        w_state_next      = S_IDLE;
                        w_grant_next      = '0;
                        w_last_owner_next = w_owner_idx;
                    end
                end else if (r_wd == WD_LAST) begin
                    w_state_next      = S_IDLE;
                    w_grant_next      = '0;
                    w_last_owner_next = w_owner_idx;
                    w_timeout_next    = 1'b1;
                    w_wd_next         = '0;
                end else begin
                    w_wd_next = r_wd + WD_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_last_owner  <= OWNER_INIT;
            r_wd          <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_grant       <= w_grant_next;
            r_last_owner  <= w_last_owner_next;
            r_wd          <= w_wd_next;
            r_timeout_err <= w_timeout_next;
        end
    end

    // Output register: coordinates load on every accepted beat, even clipped
    // ones; only on-screen beats raise the plot strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_vga_plot   <= 1'b0;
            r_clip_count <= '0;
        end else begin
            r_vga_plot <= w_accept && w_on_screen;
            if (w_accept) begin
                r_vga_x      <= w_sel_x;
                r_vga_y      <= w_sel_y;
                r_vga_colour <= w_sel_colour;
                if (!w_on_screen && (r_clip_count != 16'hFFFF)) begin
                    r_clip_count <= r_clip_count + 16'd1;
                end
            end
        end
    end

    assign req_ready   = r_grant;
    assign grant       = r_grant;
    assign vga_x       = r_vga_x;
    assign vga_y       = r_vga_y;
    assign vga_colour  = r_vga_colour;
    assign vga_plot    = r_vga_plot;
    assign clip_count  = r_clip_count;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_plot_arbiter
//
// Directed bench for vga_plot_arbiter with two requesters and TIMEOUT=8.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// the same point, so every check sees the result of the preceding edge.
// -----------------------------------------------------------------------------
module tb_vga_plot_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_last;
    logic [15:0] req_x;
    logic [13:0] req_y;
    logic [5:0]  req_colour;
    logic [1:0]  req_ready;
    logic [1:0]  grant;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [15:0] clip_count;
    logic        timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    vga_plot_arbiter #(
        .N_REQ   (2),
        .X_MAX   (160),
        .Y_MAX   (120),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_colour  (req_colour),
        .req_ready   (req_ready),
        .grant       (grant),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .clip_count  (clip_count),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic v, input logic l,
                         input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        req_valid[r]        = v;
        req_last[r]         = l;
        req_x[8*r +: 8]     = x;
        req_y[7*r +: 7]     = y;
        req_colour[3*r +: 3] = c;
    endtask

    // Expected grant after each edge of the round-robin test.
    logic [1:0] rr_tab [16] = '{2'b01, 2'b01, 2'b01, 2'b00,
                                2'b10, 2'b10, 2'b10, 2'b00,
                                2'b01, 2'b01, 2'b01, 2'b00,
                                2'b10, 2'b10, 2'b10, 2'b00};
    logic [7:0] clip_x [4] = '{8'd159, 8'd160, 8'd10, 8'd255};
    logic [6:0] clip_y [4] = '{7'd119, 7'd50, 7'd120, 7'd127};
    logic       clip_p [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic       stall_v [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int cnt [2];
        int k [2];
        logic [1:0] prev;
        int px;

        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_last   = 2'b00;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;

        // 1. Reset values, then requester 0 wins first.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst grant", grant, 0);
            check("rst ready", req_ready, 0);
            check("rst plot", vga_plot, 0);
            check("rst clip", clip_count, 0);
            check("rst terr", timeout_err, 0);
        end
        rst_n = 1'b1;
        tick();
        check("first grant", grant, 2'b01);
        drive(0, 1, 1, 8'd0, 7'd0, 3'd0);
        drive(1, 0, 0, 8'd0, 7'd0, 3'd0);
        tick();
        check("t1 plot", vga_plot, 1);
        check("t1 grant off", grant, 0);
        drive(0, 0, 0, 8'd0, 7'd0, 3'd0);

        // 2. Single five-pixel burst from requester 0.
        drive(0, 1, 0, 8'd80, 7'd60, 3'b010);
        tick();
        check("t2 grant", grant, 2'b01);
        check("t2 plot idle", vga_plot, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, (i == 4), 8'(80 + i), 7'd60, 3'b010);
            tick();
            check("t2 plot", vga_plot, 1);
            check("t2 x", vga_x, 80 + i);
            check("t2 y", vga_y, 60);
            check("t2 colour", vga_colour, 3'b010);
            check("t2 grant", grant, (i == 4) ? 2'b00 : 2'b01);
        end
        drive(0, 0, 0, 8'd0, 7'd0, 3'd0);
        tick();
        check("t2 plot end", vga_plot, 0);

        // 3. Round-robin from a fresh reset: both stream 3-pixel bursts.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cnt  = '{0, 0};
        k    = '{0, 0};
        prev = 2'b00;
        for (int s = 0; s < 16; s++) begin
            drive(0, 1, (cnt[0] == 2), 8'(20 + k[0]), 7'd10, 3'd1);
            drive(1, 1, (cnt[1] == 2), 8'(100 + k[1]), 7'd20, 3'd6);
            tick();
            check("t3 grant", grant, rr_tab[s]);
            check("t3 ready", req_ready, rr_tab[s]);
            check("t3 plot", vga_plot, (prev != 2'b00));
            for (int r = 0; r < 2; r++) begin
                if (prev[r]) begin
                    check("t3 x", vga_x, (r == 0) ? 20 + k[0] : 100 + k[1]);
                    cnt[r] = (cnt[r] == 2) ? 0 : cnt[r] + 1;
                    k[r]++;
                end
            end
            prev = rr_tab[s];
        end
        drive(0, 0, 0, 8'd0, 7'd0, 3'd0);
        drive(1, 0, 0, 8'd0, 7'd0, 3'd0);
        tick();
        check("t3 idle", grant, 0);

        // 4. Clipping: only the first of four beats is on screen.
        drive(0, 1, 0, clip_x[0], clip_y[0], 3'd5);
        tick();
        check("t4 grant", grant, 2'b01);
        for (int j = 0; j < 4; j++) begin
            drive(0, 1, (j == 3), clip_x[j], clip_y[j], 3'd5);
            tick();
            check("t4 plot", vga_plot, clip_p[j]);
            check("t4 x", vga_x, clip_x[j]);
            check("t4 clip", clip_count, j);
            check("t4 grant", grant, (j == 3) ? 2'b00 : 2'b01);
        end
        drive(0, 0, 0, 8'd0, 7'd0, 3'd0);
        tick();
        check("t4 clip final", clip_count, 3);

        // 5. Watchdog: requester 1 sends one pixel then stalls.
        drive(1, 1, 0, 8'd5, 7'd6, 3'd7);
        tick();
        check("t5 grant", grant, 2'b10);
        tick();
        check("t5 plot", vga_plot, 1);
        check("t5 x", vga_x, 5);
        drive(1, 0, 0, 8'd5, 7'd6, 3'd7);
        drive(0, 1, 0, 8'd30, 7'd40, 3'd1);
        for (int c = 1; c < 8; c++) begin
            tick();
            check("t5 terr low", timeout_err, 0);
            check("t5 grant held", grant, 2'b10);
            check("t5 plot low", vga_plot, 0);
        end
        tick();
        check("t5 terr pulse", timeout_err, 1);
        check("t5 grant revoked", grant, 0);
        tick();
        check("t5 terr end", timeout_err, 0);
        check("t5 next owner", grant, 2'b01);
        drive(0, 1, 1, 8'd30, 7'd40, 3'd1);
        tick();
        check("t5 r0 plot", vga_plot, 1);
        check("t5 r0 x", vga_x, 30);
        drive(0, 0, 0, 8'd0, 7'd0, 3'd0);

        // 6. Stall for 3 cycles mid-burst, then resume.
        px = 0;
        drive(0, 1, 0, 8'd40, 7'd50, 3'd3);
        tick();
        check("t6 grant", grant, 2'b01);
        for (int s = 0; s < 7; s++) begin
            drive(0, stall_v[s], stall_v[s] && (px == 3), 8'(40 + px), 7'd50, 3'd3);
            tick();
            check("t6 plot", vga_plot, stall_v[s]);
            check("t6 x", vga_x, stall_v[s] ? 40 + px : 39 + px);
            check("t6 terr", timeout_err, 0);
            check("t6 grant", grant, (s == 6) ? 2'b00 : 2'b01);
            if (stall_v[s]) px++;
        end
        drive(0, 0, 0, 8'd0, 7'd0, 3'd0);

        // Reset in the middle of a burst clears outputs at once.
        drive(1, 1, 0, 8'd70, 7'd70, 3'd4);
        tick();
        check("rm grant", grant, 2'b10);
        tick();
        check("rm plot", vga_plot, 1);
        drive(1, 1, 0, 8'd71, 7'd70, 3'd4);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm async plot", vga_plot, 0);
        check("rm async grant", grant, 0);
        check("rm async x", vga_x, 0);
        tick();
        check("rm held plot", vga_plot, 0);
        rst_n = 1'b1;
        drive(1, 0, 0, 8'd0, 7'd0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Shares the single VGA adapter plot port (160x120, 3-bit colour) between up to four drawing engines, such as the screen-clear filler, circle engine and Reuleaux engine, so that one top level can sequence them without muxing glue logic.
- Engines present pixels over a valid/ready handshake.
- Each engine holds the grant for a whole shape, called a burst, ending on a beat with `req_last`.
- The block clips off-screen pixels, registers the VGA outputs and recovers from engines that stall.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters, legal range 1–4.
- `X_MAX`, default 160: valid x is 0..X_MAX-1.
- `Y_MAX`, default 120: valid y is 0..Y_MAX-1.
- `TIMEOUT`, default 1024: idle cycles within a burst before the grant is revoked, minimum 2.

Ports (clock and reset first; the clock is the system CLOCK_50 domain, and reset is asynchronous and active-low):
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  N_REQ  per-requester pixel valid.
- `req_last`  in  N_REQ  marks the final pixel of a burst.
- `req_x`  in  8*N_REQ  packed x coordinate; requester i occupies bits [8i+7:8i].
- `req_y`  in  7*N_REQ  packed y coordinate, same packing.
- `req_colour`  in  3*N_REQ  packed colour, same packing.
- `req_ready`  out  N_REQ  pixel accepted when `req_valid[i]` and `req_ready[i]` are both high.
- `grant`  out  N_REQ  one-hot owner, or all zeros when idle.
- `vga_x`  out  8  to the adapter.
- `vga_y`  out  7  to the adapter.
- `vga_colour`  out  3  to the adapter.
- `vga_plot`  out  1  to the adapter.
- `clip_count`  out  16  saturating count of dropped off-screen pixels.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked.

## Operation
State machine with two states, IDLE and BURST.

IDLE:
- `grant` = 0 and `req_ready` = 0.
- If any `req_valid` bit is set, choose the winner by round-robin. The search starts at `last_owner+1` (mod N_REQ) and takes the first requester with valid high.
- Register the winner into `grant` and enter BURST on the next edge.
- `req_last` is ignored in IDLE.

BURST:
- `req_ready[i]` = `grant[i]`. It is driven from registered state only and never depends on `req_valid`.
- Non-owners see `req_ready` = 0 and must keep waiting.
- An accepted beat is one where the owner has valid and ready both high.
- If the accepted beat carries `req_last`, the block returns to IDLE on the next edge and sets `last_owner` to the owner.
- Watchdog counter:
  - Cleared on every accepted beat.
  - Increments on each BURST cycle without one.
  - When it reaches TIMEOUT-1, the next edge goes to IDLE, updates `last_owner` and pulses `timeout_err` for one cycle.

Output register, on every edge:
- `vga_plot` <= 1 only if the beat was accepted and x < X_MAX and y < Y_MAX.
- `vga_x`, `vga_y` and `vga_colour` load from the accepted beat, clipped or not. Otherwise they hold their values.
- An accepted off-screen pixel is still consumed. `vga_plot` stays 0 and `clip_count` increments, saturating at 16'hFFFF.

Reset:
- Clears `grant`, `req_ready`, `vga_x`, `vga_y`, `vga_colour`, `vga_plot`, `clip_count`, `timeout_err` and the watchdog to 0.
- The state goes to IDLE.
- `last_owner` is set to N_REQ-1, so requester 0 has first priority.

## Timing
- Arbitration takes 1 cycle. A request arriving in IDLE at edge k gives `grant`/`req_ready` high after edge k+1.
- Pixel latency is 1 cycle. A beat accepted at edge k appears on `vga_plot` and the VGA outputs after edge k.
- Throughput within a burst is 1 pixel per clock.
- There is a 1-cycle IDLE gap between bursts, so back-to-back `req_last` bursts cost N+1 cycles for N pixels.
- Last beat with another requester waiting: IDLE for 1 cycle, then the new owner is granted.
- Single-pixel burst (valid and last on the first granted cycle): legal. The block returns to IDLE after 1 BURST cycle.
- Owner drops valid mid-burst: the grant is held and the watchdog runs. Resuming before TIMEOUT continues the burst with no gap.
- Reset mid-burst: outputs clear immediately (asynchronously). The interrupted beat is not plotted.
- N_REQ = 1: degenerate round-robin that always grants requester 0.

## Test plan
1. **Reset values.** Hold `rst_n`=0 for 3 cycles with `req_valid`=2'b11.
   - All outputs stay 0.
   - After release, requester 0 is granted first.
2. **Single burst.** Requester 0 sends 5 pixels at (80,60) to (84,60), colour 3'b010, with last on the 5th.
   - `vga_plot` is high for exactly 5 consecutive cycles, starting 1 cycle after each acceptance.
   - The coordinates match the inputs.
   - `grant` falls after the 5th beat.
3. **Round-robin.** Both requesters stream 3-pixel bursts continuously.
   - Grant order is 0,1,0,1.
   - There is exactly one IDLE cycle between bursts.
   - Requester 1's ready stays 0 while requester 0 owns the grant.
4. **Clipping.** Requester 0 sends (159,119), (160,50), (10,120) and (255,127), with last on the final beat.
   - Only the first pixel plots.
   - `clip_count` = 3.
   - All 4 beats are accepted.
5. **Watchdog.** With TIMEOUT=8, requester 1 is granted, sends 1 pixel without last, then drops valid.
   - `timeout_err` pulses once, 8 cycles after the last accepted beat.
   - The grant clears and requester 0 is served next.
6. **Stall and resume.** The owner drops valid for 3 cycles mid-burst, then resumes.
   - No timeout occurs and the grant is retained.
   - All pixels plot in order.
